// File: rtl/risc16_control_fsm.sv
// Multi-cycle RiSC-16 controller: owns pc/ir and sequences FETCH/DECODE/EXEC/MEM/WB
// over a single shared req/ack memory port, driving register-file and ALU controls.
module risc16_control_fsm #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        alu_eq,
  input  logic [15:0] reg_out1,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic [2:0]  rA,
  output logic [2:0]  rB,
  output logic [2:0]  rC,
  output logic        MUX_rf,
  output logic [1:0]  MUX_tgt,
  output logic        WE_rf,
  output logic [1:0]  alu_op,
  output logic        alu_src,
  output logic [15:0] imm,
  output logic        halted
);

  // Memory handshake: mem_req rises in FETCH/MEM and stays high until the cycle
  // mem_ack=1 is sampled; mem_ack is ignored whenever mem_req is low.
  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_ADDI = 3'b001;
  localparam logic [2:0] OP_NAND = 3'b010;
  localparam logic [2:0] OP_LUI  = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_LW   = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;
  localparam logic [2:0] OP_JALR = 3'b111;

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t      state, state_nxt;
  logic [15:0] pc_nxt, ir_nxt;
  logic [15:0] pc_inc, imm7_sext;
  logic [2:0]  opcode;

  assign opcode    = ir[15:13];
  assign pc_inc    = pc + 16'd1;
  assign imm7_sext = {{9{ir[6]}}, ir[6:0]};

  // Decode fields follow ir directly, so they stay constant from DECODE to the end of the instruction.
  assign rA      = ir[12:10];
  assign rB      = ir[9:7];
  assign rC      = ir[2:0];
  assign imm     = (opcode == OP_LUI) ? {ir[9:0], 6'b0} : imm7_sext;
  assign MUX_rf  = (opcode == OP_SW) || (opcode == OP_BEQ);
  assign alu_src = (opcode == OP_ADDI) || (opcode == OP_LW) ||
                   (opcode == OP_SW)   || (opcode == OP_LUI);
  assign alu_op  = (opcode == OP_NAND) ? 2'b01 :
                   (opcode == OP_LUI)  ? 2'b10 : 2'b00;
  assign halted  = (state == S_HALT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_BOOT;
      pc    <= RESET_PC;
      ir    <= 16'h0000;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ir    <= ir_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    ir_nxt       = ir;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    WE_rf        = 1'b0;
    MUX_tgt      = 2'b00;
    case (state)
      S_BOOT:   state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ack) begin
          ir_nxt    = mem_rdata;
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC: begin
        case (opcode)
          OP_SW, OP_LW: state_nxt = S_MEM;
          OP_BEQ: begin
            state_nxt = S_FETCH;
            pc_nxt    = alu_eq ? (pc_inc + imm7_sext) : pc_inc;
          end
          OP_JALR:  state_nxt = (ir[6:0] == 7'd0) ? S_WB : S_HALT;
          default:  state_nxt = S_WB;
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OP_SW);
        if (mem_ack) begin
          pc_nxt    = pc_inc;
          state_nxt = S_FETCH;
          // Load data is only valid in the ack cycle, so the write is a single combinational pulse.
          WE_rf     = (opcode == OP_LW);
        end
      end
      S_WB: begin
        WE_rf     = 1'b1;
        MUX_tgt   = (opcode == OP_JALR) ? 2'b10 : 2'b01;
        pc_nxt    = (opcode == OP_JALR) ? reg_out1 : pc_inc;
        state_nxt = S_FETCH;
      end
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_BOOT;
    endcase
  end

endmodule

// File: tb/tb_risc16_control_fsm.sv
// Bench for risc16_control_fsm: the bench plays memory, runs directed and random
// instructions, and checks each one against an instruction-level reference model.
module tb_risc16_control_fsm;

  logic        clk, rst_n;
  logic [15:0] mem_rdata, reg_out1;
  logic        mem_ack, alu_eq;
  logic        mem_req, mem_we, mem_addr_sel, MUX_rf, WE_rf, alu_src, halted;
  logic [15:0] pc, ir, imm;
  logic [2:0]  rA, rB, rC;
  logic [1:0]  MUX_tgt, alu_op;

  int n_checks = 0;
  int n_pass   = 0;

  risc16_control_fsm #(.RESET_PC(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_eq(alu_eq), .reg_out1(reg_out1), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .pc(pc), .ir(ir), .rA(rA), .rB(rB), .rC(rC),
    .MUX_rf(MUX_rf), .MUX_tgt(MUX_tgt), .WE_rf(WE_rf), .alu_op(alu_op),
    .alu_src(alu_src), .imm(imm), .halted(halted)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic release_reset();
    @(negedge clk);
    check("rst_pc", 32'(pc), 32'h0000);
    check("rst_ir", 32'(ir), 32'h0000);
    check("rst_halted", 32'(halted), 0);
    check("rst_strobes", 32'({mem_req, mem_we, WE_rf}), 0);
    rst_n = 1'b1;
    #1;
    check("boot_no_req", 32'({mem_req, mem_we, WE_rf}), 0);
    @(negedge clk);
    check("first_fetch", 32'({mem_req, mem_addr_sel, pc}), 32'({1'b1, 1'b0, 16'h0000}));
  endtask

  task automatic assert_reset();
    rst_n = 1'b0;
    #1;
    check("async_strobes", 32'({mem_req, mem_we, WE_rf}), 0);
    release_reset();
  endtask

  // Reference model: instruction-level expectations computed from the ISA rules.
  task automatic run_instr(input logic [15:0] instr, input int fw, input int mw,
                           input logic eq, input logic [15:0] r1);
    logic [2:0]  op;
    bit          halts, is_mem, writes, fetched, was_fetched, snapped;
    logic [15:0] pc0, exp_pc, exp_imm, pc_at_we;
    logic [1:0]  exp_tgt, tgt_seen;
    logic [1:0]  exp_aop;
    logic [28:0] snap;
    int          v, exp_cyc, cyc, wc, we_cnt, data_cnt, bad, store_seen;
    op = instr[15:13];
    halts  = (op == 3'd7) && (instr[6:0] != 7'd0);
    is_mem = (op == 3'd4) || (op == 3'd5);
    writes = !(op == 3'd4 || op == 3'd6 || halts);
    pc0 = pc;
    v = int'(instr[6:0]);
    if (v > 63) v -= 128;
    exp_imm = (op == 3'd3) ? 16'(int'(instr[9:0]) * 64) : 16'(v);
    case (op)
      3'd6:    exp_pc = eq ? 16'(int'(pc0) + 1 + v) : 16'(int'(pc0) + 1);
      3'd7:    exp_pc = halts ? pc0 : r1;
      default: exp_pc = 16'(int'(pc0) + 1);
    endcase
    exp_tgt = (op == 3'd5) ? 2'b00 : (op == 3'd7) ? 2'b10 : 2'b01;
    exp_aop = (op == 3'd2) ? 2'b01 : (op == 3'd3) ? 2'b10 : 2'b00;
    exp_cyc = ((op == 3'd6 || halts) ? 3 : 4) + fw + (is_mem ? mw : 0);
    cyc = 0; wc = 0; we_cnt = 0; data_cnt = 0; bad = 0; store_seen = 0;
    fetched = 0; snapped = 0; snap = '0; tgt_seen = 2'b00; pc_at_we = pc0;
    while (1) begin
      if (halted) break;
      if (mem_req && !mem_addr_sel && fetched) break;
      if (cyc > 40) begin
        check("timeout", 32'(cyc), 32'(exp_cyc));
        break;
      end
      was_fetched = fetched;
      alu_eq = eq; reg_out1 = r1;
      mem_rdata = 16'($urandom);
      mem_ack = ($urandom_range(0, 3) == 0);
      if (mem_req) begin
        mem_ack = 1'b0;
        if (wc == (mem_addr_sel ? mw : fw)) begin
          mem_ack = 1'b1;
          wc = 0;
          if (!mem_addr_sel) begin
            mem_rdata = instr;
            fetched = 1;
          end else begin
            data_cnt++;
            store_seen = int'(mem_we);
          end
        end else wc++;
      end
      #1;
      if (mem_we && !(mem_req && mem_addr_sel)) bad++;
      if (WE_rf) begin
        we_cnt++;
        tgt_seen = MUX_tgt;
        pc_at_we = pc;
      end else if (MUX_tgt != 2'b00) bad++;
      if (was_fetched && !snapped) begin
        snapped = 1;
        snap = {rA, rB, rC, imm, MUX_rf, alu_src, alu_op};
        check("ir", 32'(ir), 32'(instr));
        check("fields", 32'({rA, rB, rC}), 32'({instr[12:10], instr[9:7], instr[2:0]}));
        check("imm", 32'(imm), 32'(exp_imm));
        check("mux_rf", 32'(MUX_rf), 32'(op == 3'd4 || op == 3'd6));
        check("alu_src", 32'(alu_src), 32'(op == 3'd1 || op == 3'd3 || op == 3'd4 || op == 3'd5));
        check("alu_op", 32'(alu_op), 32'(exp_aop));
      end else if (snapped && snap != {rA, rB, rC, imm, MUX_rf, alu_src, alu_op}) bad++;
      cyc++;
      @(negedge clk);
    end
    check("cycles", 32'(cyc), 32'(exp_cyc));
    check("pc_next", 32'(pc), 32'(exp_pc));
    check("halted", 32'(halted), 32'(halts));
    check("we_count", 32'(we_cnt), writes ? 1 : 0);
    if (writes) begin
      check("we_tgt", 32'(tgt_seen), 32'(exp_tgt));
      check("we_pc_stable", 32'(pc_at_we), 32'(pc0));
    end
    check("data_access", 32'(data_cnt), is_mem ? 1 : 0);
    check("store_strobe", 32'(store_seen), (op == 3'd4) ? 1 : 0);
    check("protocol", 32'(bad), 0);
  endtask

  task automatic halt_watch(input int n);
    int bad;
    logic [15:0] p;
    bad = 0;
    p = pc;
    for (int i = 0; i < n; i++) begin
      mem_ack = 1'($urandom);
      mem_rdata = 16'($urandom);
      @(negedge clk);
      if (mem_req || mem_we || WE_rf || !halted || pc !== p) bad++;
    end
    check("halt_absorb", 32'(bad), 0);
  endtask

  task automatic sw_abort();
    int n;
    n = 0;
    mem_ack = 1'b1;
    mem_rdata = 16'h8485;
    @(negedge clk);
    mem_ack = 1'b0;
    while (!(mem_req && mem_addr_sel) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("sw_in_mem", 32'({mem_req, mem_addr_sel, mem_we}), 32'h7);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_strobes", 32'({mem_req, mem_we, WE_rf}), 0);
    check("abort_pc", 32'(pc), 32'h0000);
    release_reset();
  endtask

  initial begin
    logic [15:0] instr;
    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0; alu_eq = 1'b0; reg_out1 = '0;
    #12;
    release_reset();
    run_instr(16'h0503, 0, 0, 1'b0, 16'h0000);   // ADD r1=r2+r3
    run_instr(16'hA505, 0, 3, 1'b0, 16'h0000);   // LW, late ack
    run_instr(16'hE000, 0, 0, 1'b0, 16'h0010);
    run_instr(16'hC57E, 0, 0, 1'b1, 16'h0000);   // BEQ taken back
    run_instr(16'hE000, 1, 0, 1'b0, 16'h0010);
    run_instr(16'hC57E, 0, 0, 1'b0, 16'h0000);   // BEQ not taken
    run_instr(16'hE000, 0, 0, 1'b0, 16'h0020);
    run_instr(16'hFC80, 0, 0, 1'b0, 16'h1234);   // JALR link
    run_instr(16'h67FF, 2, 0, 1'b0, 16'h0000);   // LUI
    run_instr(16'hE000, 0, 0, 1'b0, 16'hFFFF);
    run_instr(16'hC000, 0, 0, 1'b1, 16'h0000);   // BEQ wraps to 0
    run_instr(16'hE000, 0, 0, 1'b0, 16'h0040);
    sw_abort();
    run_instr(16'hE001, 0, 0, 1'b0, 16'h0000);   // JALR halt
    halt_watch(100);
    assert_reset();
    for (int k = 0; k < 60; k++) begin
      instr = 16'($urandom);
      if (instr[15:13] == 3'd7 && $urandom_range(0, 3) != 0) instr[6:0] = 7'd0;
      run_instr(instr, $urandom_range(0, 3), $urandom_range(0, 3),
                1'($urandom), 16'($urandom));
      if (halted) begin
        halt_watch(10);
        assert_reset();
      end
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
